bfloat_mul_pipe: RTL

BFLOAT_MUL_PIPE -- requirements
Module: bfloat_mul_pipe

---
 rtl/bfloat_mul_pipe.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bfloat_mul_pipe.sv
// rtl/bfloat_mul_pipe.sv - 3-stage bfloat16 multiplier with valid/ready handshake.
// Optional BFLOAT_MUL_RNE_EN selects round-to-nearest-even; otherwise results truncate.
module bfloat_mul_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] c,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [1:0] CLS_NORM = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    logic [7:0]  ea, eb;
    logic [6:0]  ma, mb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [1:0]  cls_in;
    logic [9:0]  exp_in;
    logic [15:0] prod_in;

    assign ea = a[14:7];
    assign eb = b[14:7];
    assign ma = a[6:0];
    assign mb = b[6:0];

    assign a_nan  = (ea == 8'hFF) && (ma != 7'd0);
    assign b_nan  = (eb == 8'hFF) && (mb != 7'd0);
    assign a_inf  = (ea == 8'hFF) && (ma == 7'd0);
    assign b_inf  = (eb == 8'hFF) && (mb == 7'd0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    always_comb begin
        cls_in = CLS_NORM;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            cls_in = CLS_NAN;
        else if (a_inf || b_inf)
            cls_in = CLS_INF;
        else if (a_zero || b_zero)
            cls_in = CLS_ZERO;
    end

    assign exp_in  = {2'b00, ea} + {2'b00, eb} - 10'd127;
    assign prod_in = {8'd0, 1'b1, ma} * {8'd0, 1'b1, mb};

    logic        v1, sign1;
    logic [1:0]  cls1;
    logic [9:0]  exp1;
    logic [15:0] prod1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            cls1  <= CLS_NORM;
            exp1  <= 10'd0;
            prod1 <= 16'd0;
        end else if (advance) begin
            v1    <= in_valid;
            sign1 <= a[15] ^ b[15];
            cls1  <= cls_in;
            exp1  <= exp_in;
            prod1 <= prod_in;
        end
    end

    logic       norm;
    logic [6:0] man_t, man_rnd;
    logic [9:0] exp_n, exp_rnd;

`ifdef BFLOAT_MUL_RNE_EN
    logic       guard, sticky, inc;
    logic [7:0] man_r8;
`else
    logic       trunc_unused;
    assign trunc_unused = ^prod1[6:0];
`endif

    always_comb begin
        norm  = prod1[15];
        man_t = norm ? prod1[14:8] : prod1[13:7];
        exp_n = exp1 + {9'd0, norm};
`ifdef BFLOAT_MUL_RNE_EN
        guard   = norm ? prod1[7] : prod1[6];
        sticky  = norm ? |prod1[6:0] : |prod1[5:0];
        inc     = guard & (sticky | man_t[0]);
        man_r8  = {1'b0, man_t} + {7'd0, inc};
        // A carry out of the 7-bit fraction means 1.111..1 rounded up to 10.000..0.
        man_rnd = man_r8[6:0];
        exp_rnd = exp_n + {9'd0, man_r8[7]};
`else
        man_rnd = man_t;
        exp_rnd = exp_n;
`endif
    end

    logic       v2, sign2;
    logic [1:0] cls2;
    logic [9:0] exp2;
    logic [6:0] man2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            sign2 <= 1'b0;
            cls2  <= CLS_NORM;
            exp2  <= 10'd0;
            man2  <= 7'd0;
        end else if (advance) begin
            v2    <= v1;
            sign2 <= sign1;
            cls2  <= cls1;
            exp2  <= exp_rnd;
            man2  <= man_rnd;
        end
    end

    logic [15:0] packed_c;

    always_comb begin
        packed_c = {sign2, 15'd0};
        case (cls2)
            CLS_NAN:  packed_c = 16'hFFFF;
            CLS_INF:  packed_c = {sign2, 8'hFF, 7'd0};
            CLS_ZERO: packed_c = {sign2, 15'd0};
            default: begin
                if ($signed(exp2) <= 10'sd0)
                    packed_c = {sign2, 15'd0};
                else if ($signed(exp2) >= 10'sd255)
                    packed_c = {sign2, 8'hFF, 7'd0};
                else
                    packed_c = {sign2, exp2[7:0], man2};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= 16'h0000;
        end else if (advance) begin
            out_valid <= v2;
            c         <= packed_c;
        end
    end

endmodule
